// File: rtl/draw_sequencer_pkg.sv
// draw_sequencer_pkg: shared constants for the frame draw path.
//   SCREEN_W / SCREEN_H : visible screen size in pixels
//   TRANSPARENT         : sprite colour key that is never plotted
//   ST_* / state_t      : frame sequencer state encoding
package draw_sequencer_pkg;

    localparam int unsigned SCREEN_W    = 160;
    localparam int unsigned SCREEN_H    = 120;
    localparam logic [7:0]  TRANSPARENT = 8'hE3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BG_RUN = 3'd1;
    localparam logic [2:0] ST_BG_REL = 3'd2;
    localparam logic [2:0] ST_SP_RUN = 3'd3;
    localparam logic [2:0] ST_SP_REL = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        BG_RUN = ST_BG_RUN,
        BG_REL = ST_BG_REL,
        SP_RUN = ST_SP_RUN,
        SP_REL = ST_SP_REL,
        FINISH = ST_FINISH
    } state_t;

endpackage

// File: rtl/draw_sequencer_handshake.sv
// start_done_handshake: runs the start/done exchange with one draw stage.
//   clk, resetn : clock, async active-low reset
//   go          : one-cycle request to launch the stage
//   start       : registered start to the stage, held until done is seen
//   done        : stage done level
//   finished    : one-cycle pulse once done has dropped back low
module start_done_handshake
    import draw_sequencer_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic go,
    input  logic done,
    output logic start,
    output logic finished
);

    // rel: start released, waiting for the stage to clear done
    logic rel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start <= 1'b0;
            rel   <= 1'b0;
        end else if (go) begin
            start <= 1'b1;
        end else if (start && done) begin
            start <= 1'b0;
            rel   <= 1'b1;
        end else if (rel && !done) begin
            rel   <= 1'b0;
        end
    end

    assign finished = rel & ~done;

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame scheduler between game logic and the VGA adapter.
// Runs the background stage then (optionally) the sprite stage, and merges
// their pixel streams into one registered, clipped plot stream.
//   frame_tick, sprite_en/x/y            : frame request and sprite setup
//   bg_start/done/x/y/colour/we          : background stage handshake + pixels
//   sp_start/done/x/y/colour/we          : sprite stage handshake + local pixels
//   vga_x/y/colour/plot                  : plot stream to the VGA adapter
//   busy, frame_done                     : sequencer status
module draw_sequencer #(
    parameter logic [7:0]  TRANSPARENT = draw_sequencer_pkg::TRANSPARENT,
    parameter int unsigned SCREEN_W    = draw_sequencer_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H    = draw_sequencer_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       sprite_en,
    input  logic [7:0] sprite_x,
    input  logic [6:0] sprite_y,
    output logic       bg_start,
    input  logic       bg_done,
    input  logic [7:0] bg_x,
    input  logic [6:0] bg_y,
    input  logic [7:0] bg_colour,
    input  logic       bg_we,
    output logic       sp_start,
    input  logic       sp_done,
    input  logic [5:0] sp_x,
    input  logic [5:0] sp_y,
    input  logic [7:0] sp_colour,
    input  logic       sp_we,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [7:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       frame_done
);
    import draw_sequencer_pkg::*;

    localparam logic [8:0] XLIM = 9'(SCREEN_W);
    localparam logic [7:0] YLIM = 8'(SCREEN_H);

    state_t     state;
    logic       pending;
    logic       en_q;
    logic [7:0] spx_q;
    logic [6:0] spy_q;
    logic       bg_go, bg_fin, sp_go, sp_fin;

    // go is combinational so start rises the cycle after the request edge
    assign bg_go = (state == IDLE) && (frame_tick || pending);
    assign sp_go = (state == BG_REL) && bg_fin && en_q;

    start_done_handshake u_bg_hs (
        .clk(clk), .resetn(resetn), .go(bg_go), .done(bg_done),
        .start(bg_start), .finished(bg_fin)
    );

    start_done_handshake u_sp_hs (
        .clk(clk), .resetn(resetn), .go(sp_go), .done(sp_done),
        .start(sp_start), .finished(sp_fin)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pending    <= 1'b0;
            en_q       <= 1'b0;
            spx_q      <= '0;
            spy_q      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // one-deep request queue; extra ticks collapse into it
            if (frame_tick && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: if (frame_tick || pending) begin
                    state   <= BG_RUN;
                    en_q    <= sprite_en;
                    spx_q   <= sprite_x;
                    spy_q   <= sprite_y;
                    pending <= 1'b0;
                    busy    <= 1'b1;
                end
                BG_RUN: if (bg_done) state <= BG_REL;
                BG_REL: if (bg_fin) begin
                    if (en_q) begin
                        state <= SP_RUN;
                    end else begin
                        state      <= FINISH;
                        frame_done <= 1'b1;
                    end
                end
                SP_RUN: if (sp_done) state <= SP_REL;
                SP_REL: if (sp_fin) begin
                    state      <= FINISH;
                    frame_done <= 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // candidate pixel from whichever stage is running; sums are kept wide so
    // off-screen sprite pixels are clipped rather than wrapped
    logic [8:0] cx;
    logic [7:0] cy;
    logic [7:0] cc;
    logic       cv;

    always_comb begin
        cx = '0;
        cy = '0;
        cc = '0;
        cv = 1'b0;
        case (state)
            BG_RUN: begin
                cx = {1'b0, bg_x};
                cy = {1'b0, bg_y};
                cc = bg_colour;
                cv = bg_we;
            end
            SP_RUN: begin
                cx = {1'b0, spx_q} + {3'b0, sp_x};
                cy = {1'b0, spy_q} + {2'b0, sp_y};
                cc = sp_colour;
                cv = sp_we && (sp_colour != TRANSPARENT);
            end
            default: ;
        endcase
    end

    logic do_plot;
    assign do_plot = cv && (cx < XLIM) && (cy < YLIM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            vga_plot <= do_plot;
            if (do_plot) begin
                vga_x      <= cx[7:0];
                vga_y      <= cy[6:0];
                vga_colour <= cc;
            end
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       frame_tick, sprite_en;
    logic [7:0] sprite_x;
    logic [6:0] sprite_y;
    logic       bg_start, bg_done, bg_we;
    logic [7:0] bg_x, bg_colour;
    logic [6:0] bg_y;
    logic       sp_start, sp_done, sp_we;
    logic [5:0] sp_x, sp_y;
    logic [7:0] sp_colour;
    logic [7:0] vga_x, vga_colour;
    logic [6:0] vga_y;
    logic       vga_plot, busy, frame_done;

    draw_sequencer dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .bg_start(bg_start), .bg_done(bg_done), .bg_x(bg_x), .bg_y(bg_y),
        .bg_colour(bg_colour), .bg_we(bg_we),
        .sp_start(sp_start), .sp_done(sp_done), .sp_x(sp_x), .sp_y(sp_y),
        .sp_colour(sp_colour), .sp_we(sp_we),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stage models ----------------
    int bg_npix = 4;

    typedef struct { logic [5:0] x; logic [5:0] y; logic [7:0] c; } spx_t;
    spx_t sp_list[$];
    int   sp_we_cyc[$];

    initial begin
        bg_done = 0; bg_we = 0; bg_x = 0; bg_y = 0; bg_colour = 0;
        forever begin
            @(negedge clk);
            if (bg_start && !bg_done) begin
                for (int i = 0; i < bg_npix; i++) begin
                    bg_we = 1; bg_x = 8'(i % 160); bg_y = 7'(i / 160); bg_colour = 8'(i);
                    @(negedge clk);
                end
                bg_we = 0;
                bg_done = 1;
            end else if (!bg_start && bg_done) begin
                bg_done = 0;
            end
        end
    end

    initial begin
        sp_done = 0; sp_we = 0; sp_x = 0; sp_y = 0; sp_colour = 0;
        forever begin
            @(negedge clk);
            if (sp_start && !sp_done) begin
                foreach (sp_list[k]) begin
                    sp_we = 1; sp_x = sp_list[k].x; sp_y = sp_list[k].y; sp_colour = sp_list[k].c;
                    sp_we_cyc.push_back(cyc);
                    @(negedge clk);
                end
                sp_we = 0;
                sp_done = 1;
            end else if (!sp_start && sp_done) begin
                sp_done = 0;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [22:0] plot_q[$];
    int          plot_cyc[$];
    int          fd_cnt = 0, bg_rise = 0, sp_rise = 0;
    logic        bg_d = 0, sp_d = 0;

    always @(negedge clk) begin
        if (vga_plot) begin
            plot_q.push_back({vga_x, vga_y, vga_colour});
            plot_cyc.push_back(cyc);
        end
        if (frame_done) fd_cnt++;
        if (bg_start && !bg_d) bg_rise++;
        if (sp_start && !sp_d) sp_rise++;
        bg_d = bg_start;
        sp_d = sp_start;
    end

    task automatic clear_mon();
        plot_q.delete(); plot_cyc.delete(); sp_we_cyc.delete();
        fd_cnt = 0; bg_rise = 0; sp_rise = 0;
    endtask

    task automatic pulse_tick();
        @(negedge clk); frame_tick = 1;
        @(negedge clk); frame_tick = 0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int n = 0;
        while (!frame_done && n < maxc) begin @(negedge clk); n++; end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout waiting frame_done: got %b want 1", nm, frame_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 0; frame_tick = 0; sprite_en = 0; sprite_x = 0; sprite_y = 0;
        repeat (3) @(negedge clk);
        checks++; if ({bg_start, sp_start, vga_plot, busy, frame_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {bg_start, sp_start, vga_plot, busy, frame_done}); end
        checks++; if ({vga_x, vga_y, vga_colour} !== 23'd0) begin
            errors++; $display("FAIL reset_data got %h want 0", {vga_x, vga_y, vga_colour}); end
        resetn = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bg_only();
        clear_mon();
        bg_npix = 19200; sprite_en = 0;
        @(negedge clk); frame_tick = 1;
        @(negedge clk); frame_tick = 0;
        checks++; if (bg_start !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL bg_start_latency got start=%b busy=%b want 1 1", bg_start, busy); end
        wait_done(25000, "bg_only_done");
        repeat (5) @(negedge clk);
        checks++; if (plot_q.size() != 19200) begin
            errors++; $display("FAIL bg_plot_count got %0d want 19200", plot_q.size()); end
        checks++; if (plot_q.size() > 0 && plot_q[plot_q.size()-1] !== {8'd159, 7'd119, 8'hFF}) begin
            errors++; $display("FAIL bg_last_plot got %h want %h", plot_q[plot_q.size()-1], {8'd159, 7'd119, 8'hFF}); end
        checks++; if (sp_rise != 0) begin
            errors++; $display("FAIL bg_no_sp_start got %0d want 0", sp_rise); end
        checks++; if (fd_cnt != 1) begin
            errors++; $display("FAIL bg_frame_done_count got %0d want 1", fd_cnt); end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL bg_idle_busy got %b want 0", busy); end
        bg_npix = 4;
    endtask

    task automatic test_sprite();
        clear_mon();
        sprite_en = 1; sprite_x = 8'd100; sprite_y = 7'd50;
        sp_list.delete();
        sp_list.push_back('{x: 6'd10, y: 6'd5, c: 8'h1C});
        sp_list.push_back('{x: 6'd3,  y: 6'd3, c: 8'hE3});   // transparent
        pulse_tick();
        wait_done(200, "sprite_done");
        repeat (3) @(negedge clk);
        checks++; if (plot_q.size() != 5) begin
            errors++; $display("FAIL sprite_plot_count got %0d want 5", plot_q.size()); end
        checks++; if (plot_q.size() >= 5 && plot_q[4] !== {8'd110, 7'd55, 8'h1C}) begin
            errors++; $display("FAIL sprite_plot got %h want %h", plot_q[4], {8'd110, 7'd55, 8'h1C}); end
        checks++; if (plot_cyc.size() >= 5 && sp_we_cyc.size() >= 1 && plot_cyc[4] != sp_we_cyc[0] + 1) begin
            errors++; $display("FAIL sprite_latency got %0d want %0d", plot_cyc[4], sp_we_cyc[0] + 1); end
        checks++; if (sp_rise != 1 || fd_cnt != 1) begin
            errors++; $display("FAIL sprite_handshake got sp=%0d fd=%0d want 1 1", sp_rise, fd_cnt); end
    endtask

    task automatic test_clip();
        clear_mon();
        sprite_en = 1; sprite_x = 8'd150; sprite_y = 7'd110;
        sp_list.delete();
        sp_list.push_back('{x: 6'd0,  y: 6'd0,  c: 8'hAA});
        sp_list.push_back('{x: 6'd9,  y: 6'd9,  c: 8'hBB});
        sp_list.push_back('{x: 6'd10, y: 6'd0,  c: 8'hCC});
        sp_list.push_back('{x: 6'd0,  y: 6'd10, c: 8'hDD});
        sp_list.push_back('{x: 6'd39, y: 6'd39, c: 8'hEE});
        pulse_tick();
        wait_done(200, "clip_done");
        repeat (3) @(negedge clk);
        checks++; if (plot_q.size() != 6) begin
            errors++; $display("FAIL clip_plot_count got %0d want 6", plot_q.size()); end
        checks++; if (plot_q.size() >= 6 && plot_q[4] !== {8'd150, 7'd110, 8'hAA}) begin
            errors++; $display("FAIL clip_origin got %h want %h", plot_q[4], {8'd150, 7'd110, 8'hAA}); end
        checks++; if (plot_q.size() >= 6 && plot_q[5] !== {8'd159, 7'd119, 8'hBB}) begin
            errors++; $display("FAIL clip_corner got %h want %h", plot_q[5], {8'd159, 7'd119, 8'hBB}); end
        // origin at the coordinate maximum: sums would wrap to 0 if truncated
        clear_mon();
        sprite_x = 8'd255; sprite_y = 7'd127;
        sp_list.delete();
        sp_list.push_back('{x: 6'd1, y: 6'd1, c: 8'h55});
        sp_list.push_back('{x: 6'd0, y: 6'd0, c: 8'h66});
        pulse_tick();
        wait_done(200, "wrap_done");
        repeat (3) @(negedge clk);
        checks++; if (plot_q.size() != 4) begin
            errors++; $display("FAIL clip_no_wrap got %0d plots want 4", plot_q.size()); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        sprite_en = 0; bg_npix = 20;
        pulse_tick();
        repeat (4) @(negedge clk);
        pulse_tick();
        repeat (2) @(negedge clk);
        pulse_tick();
        wait_done(200, "b2b_first");
        @(negedge clk);
        wait_done(200, "b2b_second");
        repeat (40) @(negedge clk);
        checks++; if (fd_cnt != 2) begin
            errors++; $display("FAIL b2b_frames got %0d want 2", fd_cnt); end
        checks++; if (bg_rise != 2) begin
            errors++; $display("FAIL b2b_bg_starts got %0d want 2", bg_rise); end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
        bg_npix = 4;
    endtask

    task automatic test_reset_mid_sprite();
        int n = 0;
        clear_mon();
        sprite_en = 1; sprite_x = 8'd20; sprite_y = 7'd20;
        sp_list.delete();
        for (int i = 0; i < 10; i++) sp_list.push_back('{x: 6'(i + 1), y: 6'(i + 1), c: 8'h40});
        pulse_tick();
        while (!sp_start && n < 100) begin @(negedge clk); n++; end
        checks++; if (sp_start !== 1'b1) begin
            errors++; $display("FAIL rst_sp_reach got %b want 1", sp_start); end
        repeat (3) @(negedge clk);
        #2 resetn = 0;
        #1;
        checks++; if ({bg_start, sp_start, vga_plot, busy, frame_done} !== 5'b0) begin
            errors++; $display("FAIL rst_async_ctrl got %b want 00000", {bg_start, sp_start, vga_plot, busy, frame_done}); end
        checks++; if ({vga_x, vga_y, vga_colour} !== 23'd0) begin
            errors++; $display("FAIL rst_async_data got %h want 0", {vga_x, vga_y, vga_colour}); end
        repeat (2) @(negedge clk);
        resetn = 1;
        repeat (30) @(negedge clk);
        checks++; if (fd_cnt != 0) begin
            errors++; $display("FAIL rst_no_frame_done got %0d want 0", fd_cnt); end
        @(negedge clk); frame_tick = 1;
        @(negedge clk); frame_tick = 0;
        checks++; if (bg_start !== 1'b1 || sp_start !== 1'b0) begin
            errors++; $display("FAIL rst_restart got bg=%b sp=%b want 1 0", bg_start, sp_start); end
        wait_done(300, "rst_restart_done");
        repeat (3) @(negedge clk);
        checks++; if (fd_cnt != 1) begin
            errors++; $display("FAIL rst_restart_frames got %0d want 1", fd_cnt); end
    endtask

    initial begin
        test_reset();
        test_bg_only();
        test_sprite();
        test_clip();
        test_back_to_back();
        test_reset_mid_sprite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Per-frame scheduler between the game logic and the VGA adapter. On each frame request it runs the 160x120 background draw stage, then the 40x40 sprite draw stage. It does this through their start/done handshakes. It merges both pixel streams into one registered plot stream, adding the sprite origin and applying transparency and screen clipping. It sits downstream of the two draw stages and directly upstream of the VGA adapter.

## Interface
Parameters:
- `TRANSPARENT`, 8'hE3 — sprite colour value that is never plotted.
- `SCREEN_W`, 160 — plots with x ≥ this are suppressed.
- `SCREEN_H`, 120 — plots with y ≥ this are suppressed.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `frame_tick`  in  1  — one-cycle redraw request.
- `sprite_en`  in  1  — draw sprite this frame; latched at frame start.
- `sprite_x`  in  8  — sprite origin x; latched at frame start.
- `sprite_y`  in  7  — sprite origin y; latched at frame start.
- `bg_start`  out  1  — start to background stage; held until handshake completes.
- `bg_done`  in  1  — background stage done.
- `bg_x`  in  8  — background pixel x.
- `bg_y`  in  7  — background pixel y.
- `bg_colour`  in  8  — background pixel colour.
- `bg_we`  in  1  — background pixel valid.
- `sp_start`  out  1  — start to sprite stage.
- `sp_done`  in  1  — sprite stage done.
- `sp_x`  in  6  — local sprite offset x, 0..39.
- `sp_y`  in  6  — local sprite offset y, 0..39.
- `sp_colour`  in  8  — sprite pixel colour.
- `sp_we`  in  1  — sprite pixel valid.
- `vga_x`  out  8  — plot x to VGA adapter.
- `vga_y`  out  7  — plot y to VGA adapter.
- `vga_colour`  out  8  — plot colour.
- `vga_plot`  out  1  — plot strobe.
- `busy`  out  1  — high in any state but IDLE.
- `frame_done`  out  1  — one-cycle pulse when a frame completes.

## Operation
States: IDLE, BG_RUN, BG_REL, SP_RUN, SP_REL, FINISH.

Transitions:
- IDLE → BG_RUN on `frame_tick` or `pending`. On entry: latch `sprite_en`, `sprite_x`, `sprite_y`; clear `pending`.
- BG_RUN: `bg_start`=1. On `bg_done`=1 → BG_REL.
- BG_REL: `bg_start`=0. Wait for `bg_done`=0, which happens when the stage returns to idle and clears its counters. Then go to SP_RUN if the latched enable is set, else FINISH.
- SP_RUN / SP_REL: same pattern as the background states, using `sp_start` / `sp_done`. SP_REL exits to FINISH.
- FINISH: `frame_done`=1 for one cycle → IDLE.

Request handling:
- A `frame_tick` while `busy` sets a one-deep `pending` flag. Further ticks while `pending` is set are dropped.
- A tick in FINISH also sets `pending`; the next frame then starts from IDLE on the following cycle.

Pixel path (only the stream of the active stage is forwarded):
- BG_RUN: candidate = {`bg_x`, `bg_y`, `bg_colour`}; valid = `bg_we`.
- SP_RUN: candidate x = latched `sprite_x` + `sp_x` at 9 bits; candidate y = latched `sprite_y` + `sp_y` at 8 bits. Valid = `sp_we` and `sp_colour` ≠ `TRANSPARENT`.
- A candidate is plotted only if x < `SCREEN_W` and y < `SCREEN_H`. Coordinates never wrap: a sum ≥ the bound is suppressed, not truncated.
- `we` strobes arriving in any other state are ignored.

Reset:
- Async `resetn` low forces IDLE. All outputs, `pending`, and the latched fields go to 0 immediately.
- Reset mid-frame abandons the frame. No `frame_done` is produced.

## Timing
- Pixel path is one register stage: a valid strobe at cycle n gives `vga_plot` at cycle n+1, with the registered coordinates and colour.
- `frame_tick` in IDLE at cycle n: `bg_start` high from cycle n+1.
- `bg_start` falls the cycle after `bg_done` is sampled high.
- `busy` is high from the cycle after acceptance through FINISH inclusive.
- Outputs that are 0 out of reset: `bg_start`, `sp_start`, `vga_plot`, `busy`, `frame_done`. The remaining outputs are also 0.

## Structure
- Shared draw package holds:
  - screen constants `SCREEN_W` and `SCREEN_H`;
  - the `TRANSPARENT` colour;
  - the state encoding localparams.
- One natural sub-module: `start_done_handshake`. It runs the RUN/REL pair for one stage: `go` in, `start` out, `done` in, `finished` pulse out. It is instantiated twice.

## Test plan
- Tick in IDLE with `sprite_en`=0. Background model asserts done after 19200 plots. Required: exactly 19200 `vga_plot` pulses, no `sp_start`, one `frame_done`.
- Sprite origin (100,50), `sprite_en`=1, sprite pixel at local (10,5) with colour 8'h1C. Required: plot at (110,55) with colour 8'h1C, one cycle after `sp_we`.
- Sprite origin (150,110). Required: pixels with local x ≥ 10 or local y ≥ 10 are suppressed. Local (0,0) plots at (150,110).
- Sprite pixel colour 8'hE3. Required: no `vga_plot` for that pixel.
- Two `frame_tick` pulses during BG_RUN. Required: exactly one extra frame runs after `frame_done`, then return to IDLE.
- `resetn` pulsed low mid-SP_RUN. Required: all outputs 0 asynchronously, no `frame_done`, and a new tick restarts at BG_RUN.
